// File: rtl/fpu_mult_pipe.sv
// Pipelined FP multiplier: unrounded {sign, exp, frac, g, r, s} result, valid/ready handshake.
// Define FPU_MULT_FLAGS_EN to add the pipelined {invalid, overflow, underflow} flags port.
`timescale 1ns/1ps

module fpu_mult_core #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0]   opa,
    input  logic [EXP_W+MAN_W:0]   opb,
    output logic [EXP_W+MAN_W+3:0] res,
    output logic [2:0]             flg
);
    localparam int               PW       = 2*MAN_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W+1:0] BIAS_X   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W+1:0] EMAX_X   = {2'b00, EXP_ONES};

    logic             sa, sb, sgn;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;

    assign {sa, ea, fa} = opa;
    assign {sb, eb, fb} = opb;
    assign sgn = sa ^ sb;

    // exponent field 0 is zero regardless of fraction (subnormals flushed)
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inv_op, nan_res;
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == EXP_ONES) && (fa == '0);
    assign b_inf   = (eb == EXP_ONES) && (fb == '0);
    assign a_nan   = (ea == EXP_ONES) && (fa != '0);
    assign b_nan   = (eb == EXP_ONES) && (fb != '0);
    assign inv_op  = (a_inf & b_zero) | (b_inf & a_zero);
    assign nan_res = a_nan | b_nan | inv_op;

    logic [PW-1:0] ma, mb, p, pn;
    logic          n, shout, unused_hi;

    assign ma        = {{(MAN_W+1){1'b0}}, 1'b1, fa};
    assign mb        = {{(MAN_W+1){1'b0}}, 1'b1, fb};
    assign p         = ma * mb;
    assign n         = p[PW-1];
    assign pn        = n ? (p >> 1) : p;
    assign shout     = n & p[0];
    assign unused_hi = ^pn[PW-1:PW-2];

    // two extra bits keep the biased sum from wrapping in either direction
    logic [EXP_W+1:0] e;
    logic             ovf, unf;
    assign e   = {2'b00, ea} + {2'b00, eb} - BIAS_X + {{(EXP_W+1){1'b0}}, n};
    assign ovf = !e[EXP_W+1] && (e >= EMAX_X);
    assign unf = e[EXP_W+1] || (e == '0);

    always_comb begin
        res = '0;
        flg = '0;
        if (nan_res) begin
            res    = {1'b0, EXP_ONES, 1'b1, {(MAN_W+2){1'b0}}};
            flg[2] = inv_op | (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]);
        end else if (a_inf | b_inf) begin
            res = {sgn, EXP_ONES, {(MAN_W+3){1'b0}}};
        end else if (a_zero | b_zero) begin
            res = {sgn, {(EXP_W+MAN_W+3){1'b0}}};
        end else if (ovf) begin
            res    = {sgn, EXP_ONES, {(MAN_W+3){1'b0}}};
            flg[1] = 1'b1;
        end else if (unf) begin
            res    = {sgn, {(EXP_W+MAN_W+3){1'b0}}};
            flg[0] = 1'b1;
        end else begin
            res = {sgn, e[EXP_W-1:0], pn[2*MAN_W-1:MAN_W], pn[MAN_W-1], pn[MAN_W-2],
                   (|pn[MAN_W-3:0]) | shout};
        end
    end
endmodule

module fpu_mult_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opa,
    input  logic [EXP_W+MAN_W:0]   opb,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W+3:0] out,
    output logic [TAG_W-1:0]       out_tag
`ifdef FPU_MULT_FLAGS_EN
    ,
    output logic [2:0]             flags
`endif
);
    localparam int RES_W = EXP_W + MAN_W + 4;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic [TAG_W-1:0] tag;
`ifdef FPU_MULT_FLAGS_EN
        logic [2:0]       flg;
`endif
    } stage_t;

    logic [RES_W-1:0] core_res;
    logic [2:0]       core_flg;

    fpu_mult_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
        .opa (opa),
        .opb (opb),
        .res (core_res),
        .flg (core_flg)
    );

    stage_t              stg_in;
    stage_t [STAGES:1]   stg_q;
    stage_t [STAGES:0]   stg_pipe;
    logic   [STAGES:1]   vld_q;
    logic   [STAGES:0]   vld_pipe;
    logic                en;

`ifdef FPU_MULT_FLAGS_EN
    assign stg_in = {core_res, in_tag, core_flg};
`else
    logic [2:0] unused_flg;
    assign unused_flg = core_flg;
    assign stg_in     = {core_res, in_tag};
`endif

    assign vld_pipe = {vld_q, in_valid};
    assign stg_pipe = {stg_q, stg_in};
    assign en       = !vld_q[STAGES] || out_ready;
    assign in_ready = en;

    // one global enable: the whole pipe advances or the whole pipe holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            stg_q <= '0;
        end else if (en) begin
            for (int s = 1; s <= STAGES; s++) begin
                vld_q[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) stg_q[s] <= stg_pipe[s-1];
            end
        end
    end

    assign out_valid = vld_q[STAGES];
    assign out       = stg_q[STAGES].res;
    assign out_tag   = stg_q[STAGES].tag;
`ifdef FPU_MULT_FLAGS_EN
    assign flags     = stg_q[STAGES].flg;
`endif
endmodule

// File: tb/tb_fpu_mult_pipe.sv
// Bench for fpu_mult_pipe: directed vectors, backpressure, async reset and a random scoreboard run.
`timescale 1ns/1ps

module tb_fpu_mult_pipe;
    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [34:0] out;
    logic [3:0]  out_tag;
`ifdef FPU_MULT_FLAGS_EN
    logic [2:0]  flags;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [34:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fpu_mult_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opa       (opa),
        .opb       (opb),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag)
`ifdef FPU_MULT_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: value of the product is p / 2^46, normalised into [1,2)
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        exp_t            r;
        int              ea, eb, e;
        logic [22:0]     fa, fb, fr;
        logic [7:0]      e8;
        logic            sg, az, bz, ai, bi, an, bn, bad;
        longint unsigned p, keep, lost;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        sg = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        bad = (ai && bz) || (bi && az);
        r.tag = t;
        r.flg = 3'b000;
        r.res = '0;
        if (an || bn || bad) begin
            r.res    = 35'h3FE000000;
            r.flg[2] = bad || (an && !fa[22]) || (bn && !fb[22]);
        end else if (ai || bi) begin
            r.res = {sg, 8'hFF, 26'd0};
        end else if (az || bz) begin
            r.res = {sg, 34'd0};
        end else begin
            p = (64'h800000 + 64'(fa)) * (64'h800000 + 64'(fb));
            if (p >= (64'd1 << 47)) begin
                e = ea + eb - 126; keep = p / 2; lost = p % 2;
            end else begin
                e = ea + eb - 127; keep = p; lost = 0;
            end
            if (e >= 255) begin
                r.res = {sg, 8'hFF, 26'd0}; r.flg[1] = 1'b1;
            end else if (e <= 0) begin
                r.res = {sg, 34'd0}; r.flg[0] = 1'b1;
            end else begin
                e8 = e[7:0];
                fr = keep[45:23];
                r.res = {sg, e8, fr, keep[22], keep[21], (keep[20:0] != 0) || (lost != 0)};
            end
        end
        return r;
    endfunction

    // Scoreboard monitor: records accepts, checks drains and output stability under stall
    logic        prev_stall = 1'b0;
    logic [34:0] prev_out = '0;
    logic [3:0]  prev_tag = '0;
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_out", 64'(out), 64'(prev_out));
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (in_valid && in_ready) sb_q.push_back(model(opa, opb, in_tag));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_out: got %h tag %h, expected no result", out, out_tag);
                end else begin
                    x = sb_q.pop_front();
                    chk("sb_out", 64'(out), 64'(x.res));
                    chk("sb_tag", 64'(out_tag), 64'(x.tag));
`ifdef FPU_MULT_FLAGS_EN
                    chk("sb_flags", 64'(flags), 64'(x.flg));
`endif
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_out   <= out;
            prev_tag   <= out_tag;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        logic took;
        int   guard;
        guard = 0;
        opa = a; opb = b; in_tag = t; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) break;
            guard++;
            if (guard > 200) begin
                n_vec++; n_err++;
                $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] t, input logic [34:0] er, input logic [2:0] ef);
        int lat;
        out_ready = 1'b1;
        send(a, b, t);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(STAGES));
        chk({nm, "_out"}, 64'(out), 64'(er));
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
`ifdef FPU_MULT_FLAGS_EN
        chk({nm, "_flags"}, 64'(flags), 64'(ef));
`else
        if (ef > 3'd7) $display("unreachable");
`endif
        @(posedge clk); #1;
    endtask

    task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [34:0] er, input logic [2:0] ef);
        exp_t x;
        x = model(a, b, 4'd0);
        chk({nm, "_model"}, 64'(x.res), 64'(er));
        chk({nm, "_model_flg"}, 64'(x.flg), 64'(ef));
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && g < 300) begin
            @(posedge clk); #1; g++;
        end
        chk(nm, 64'(sb_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       begin e = 8'hFF; f = '0; end
            3:       e = 8'($urandom_range(1, 20));
            4:       e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    bit rnd_done = 1'b0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
`ifdef FPU_MULT_FLAGS_EN
        chk("rst_flags", 64'(flags), 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // hand-derived values pinning the reference model
        pin("basic",  32'h3FC00000, 32'h40000000, 35'h202000000, 3'b000);
        pin("norm",   32'h3FC00000, 32'h3FC00000, 35'h200800000, 3'b000);
        pin("sticky", 32'h3F800001, 32'h3F800001, 35'h1FC000011, 3'b000);
        pin("inf0",   32'h7F800000, 32'h00000000, 35'h3FE000000, 3'b100);
        pin("ovf",    32'h7F000000, 32'h7F000000, 35'h3FC000000, 3'b010);
        pin("unf",    32'h00800000, 32'h00800000, 35'h000000000, 3'b001);

        // directed vectors against literal expectations
        @(posedge clk); #1;
        directed("basic",    32'h3FC00000, 32'h40000000, 4'd5,  35'h202000000, 3'b000);
        directed("norm",     32'h3FC00000, 32'h3FC00000, 4'd6,  35'h200800000, 3'b000);
        directed("sticky",   32'h3F800001, 32'h3F800001, 4'd7,  35'h1FC000011, 3'b000);
        directed("inf_x_0",  32'h7F800000, 32'h00000000, 4'd8,  35'h3FE000000, 3'b100);
        directed("ovf",      32'h7F000000, 32'h7F000000, 4'd9,  35'h3FC000000, 3'b010);
        directed("unf",      32'h00800000, 32'h00800000, 4'd10, 35'h000000000, 3'b001);
        directed("neg",      32'hBF800000, 32'h3F800000, 4'd11, 35'h5FC000000, 3'b000);
        directed("qnan",     32'h7FC00000, 32'h3F800000, 4'd12, 35'h3FE000000, 3'b000);
        directed("snan",     32'h7F800001, 32'h3F800000, 4'd13, 35'h3FE000000, 3'b100);
        directed("neg_inf",  32'hFF800000, 32'h40000000, 4'd14, 35'h7FC000000, 3'b000);
        directed("neg_zero", 32'h00000000, 32'hC0A00000, 4'd15, 35'h400000000, 3'b000);
        directed("daz",      32'h00400000, 32'h3F800000, 4'd1,  35'h000000000, 3'b000);
        directed("e255",     32'h5F800000, 32'h5F800000, 4'd2,  35'h3FC000000, 3'b010);
        directed("e254",     32'h5F000000, 32'h5F800000, 4'd3,  35'h3F8000000, 3'b000);
        directed("e0",       32'h20000000, 32'h1F800000, 4'd4,  35'h000000000, 3'b001);
        directed("e1",       32'h20000000, 32'h20000000, 4'd5,  35'h004000000, 3'b000);

        // backpressure: 8 back-to-back ops into a stalled consumer
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h3F800000 + 32'(i << 20), 32'h40000000 + 32'(i), 4'(i));
            end
            begin
                repeat (12) begin
                    @(negedge clk);
                    if (out_valid) chk("bp_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // async reset with three ops in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h40400000, 32'h40400000 + 32'(i), 4'(i + 3));
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out", 64'(out), 64'd0);
        chk("mid_rst_tag", 64'(out_tag), 64'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        directed("post_rst", 32'h3FC00000, 32'h40000000, 4'd9, 35'h202000000, 3'b000);

        // random operands with random gaps and random consumer stalls
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    send(rnd_op(), rnd_op(), 4'(i));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    if (!rnd_done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("rnd_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
